rom_port: RTL and testbench

Multi-channel, byte-addressed read-only memory with per-channel valid/ready request and response handshakes. It is the successor to the single-port ROM and is built on `generic_mem` with its write port tied off. It lets the instruction-fetch and data-load paths share one ROM image through round-robin arbitration. Each channel may have one outstanding request, and its response is held until consumed.

---
 rtl/rom_port.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rom_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rom_port.sv
// ---------------------------------------------------------------------------
// rom_port: multi-channel, byte-addressed read-only memory.
//
// Several requestors share one ROM image through round-robin arbitration.
// Each channel may have one request outstanding, and its response is held
// until the requestor consumes it. The storage is a generic_mem instance
// with its write port tied off. The image is loaded into u_mem.mem by the
// surrounding environment before reset is released.
//
// Build option:
//   ROM_ERR_CHECK_EN  defined   -> misaligned or out-of-range requests get
//                                  rsp_err=1 and rsp_data=0.
//                     undefined -> low address bits and bits at or above
//                                  $clog2(MEMSIZE) are ignored (wrap-around),
//                                  and rsp_err is always 0.
//
// Ports (rom_port):
//   clock      in   1                 rising-edge clock
//   reset_n    in   1                 asynchronous active-low reset
//   req_valid  in   NCH               request valid, one bit per channel
//   req_ready  out  NCH               request accepted this cycle (one-hot/0)
//   req_addr   in   NCH*ADDR_W        byte address, channel c at [c*ADDR_W +: ADDR_W]
//   rsp_valid  out  NCH               response valid
//   rsp_ready  in   NCH               response consumed
//   rsp_data   out  NCH*WORDSIZE*8    read word, channel c at [c*WORDSIZE*8 +: WORDSIZE*8]
//   rsp_err    out  NCH               response is a fault
//
// Per-channel state:
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | no request outstanding; eligible when req_valid is high
//   ST_INFLIGHT  | granted last edge; memory read in progress
//   ST_HELD      | response registered; rsp_valid high until rsp_ready
// ---------------------------------------------------------------------------

// generic_mem: single-port-read / single-port-write synchronous RAM.
//   clock  in   1    rising-edge clock
//   we     in   1    write enable
//   waddr  in   AW   write word address
//   wdata  in   DW   write data
//   raddr  in   AW   read word address
//   rdata  out  DW   read data, registered (valid one edge after raddr)
module generic_mem #(
    parameter int    DW       = 32,
    parameter int    DEPTH    = 256,
    parameter int    AW       = 32,
    parameter string DATAFILE = "data_file_not_defined"
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;
    logic          unused_mem_bits;

    always_comb begin
        rdata_d = mem[raddr[IW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

    // Upper address bits beyond the array depth are ignored; the image file
    // name is only carried for flows that preload the array from it.
    assign unused_mem_bits = (^raddr) ^ (^waddr) ^ (DATAFILE == "data_file_not_defined");

endmodule

module rom_port #(
    parameter int    WORDSIZE = 4,
    parameter int    MEMSIZE  = 32*1024,
    parameter string DATAFILE = "data_file_not_defined",
    parameter int    NCH      = 2,
    parameter int    ADDR_W   = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NCH-1:0]            req_valid,
    output logic [NCH-1:0]            req_ready,
    input  logic [NCH*ADDR_W-1:0]     req_addr,
    output logic [NCH-1:0]            rsp_valid,
    input  logic [NCH-1:0]            rsp_ready,
    output logic [NCH*WORDSIZE*8-1:0] rsp_data,
    output logic [NCH-1:0]            rsp_err
);

    localparam int DW     = WORDSIZE * 8;
    localparam int OFF_W  = $clog2(WORDSIZE);
    localparam int MEM_AW = $clog2(MEMSIZE);
    localparam int IDX_W  = MEM_AW - OFF_W;
    localparam int DEPTH  = MEMSIZE / WORDSIZE;
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_HELD     = 2'd2
    } ch_state_e;

    ch_state_e       state_q [NCH];
    ch_state_e       state_d [NCH];
    logic [CH_W-1:0] last_grant_q, last_grant_d;
    logic [CH_W-1:0] pipe_ch_q, pipe_ch_d;
    logic            pipe_err_q, pipe_err_d;
    logic [DW-1:0]   rsp_data_q [NCH];
    logic [DW-1:0]   rsp_data_d [NCH];
    logic [NCH-1:0]  rsp_err_q, rsp_err_d;

    logic [NCH-1:0]    eligible;
    logic [NCH-1:0]    grant;
    logic              grant_any;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   arb_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_fault;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DW-1:0]     mem_rdata;
    logic              unused_addr_bits;

    // A HELD channel stays ineligible even in the cycle its response drains,
    // so a channel's next grant comes one cycle after its handshake.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NCH; c++) begin
            eligible[c] = req_valid[c] && (state_q[c] == ST_IDLE);
        end
    end

    // Round-robin: search starts one past the last granted channel.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_ch  = last_grant_q;
        arb_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            arb_idx = CH_W'((int'(last_grant_q) + i) % NCH);
            if (!grant_any && eligible[arb_idx]) begin
                grant_any      = 1'b1;
                grant_ch       = arb_idx;
                grant[arb_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant[c]) begin
                grant_addr = req_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end

    assign grant_idx = grant_addr[MEM_AW-1:OFF_W];
    assign mem_raddr = ADDR_W'(grant_idx);

`ifdef ROM_ERR_CHECK_EN
    assign grant_fault = ((grant_addr & ADDR_W'(WORDSIZE - 1)) != '0) ||
                         (grant_addr >= ADDR_W'(MEMSIZE));
`else
    assign grant_fault = 1'b0;
`endif

    // Address bits outside the word index only matter for fault detection.
    assign unused_addr_bits = ^grant_addr;

    generic_mem #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .AW       (ADDR_W),
        .DATAFILE (DATAFILE)
    ) u_mem (
        .clock (clock),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]    <= ST_IDLE;
                rsp_data_q[c] <= '0;
            end
            last_grant_q <= CH_W'(NCH - 1);
            pipe_ch_q    <= '0;
            pipe_err_q   <= 1'b0;
            rsp_err_q    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]    <= state_d[c];
                rsp_data_q[c] <= rsp_data_d[c];
            end
            last_grant_q <= last_grant_d;
            pipe_ch_q    <= pipe_ch_d;
            pipe_err_q   <= pipe_err_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (grant[c]) begin
                        state_d[c] = ST_INFLIGHT;
                    end
                end
                ST_INFLIGHT: begin
                    state_d[c] = ST_HELD;
                end
                ST_HELD: begin
                    if (rsp_ready[c]) begin
                        state_d[c] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                end
            endcase
        end

        last_grant_d = grant_any ? grant_ch : last_grant_q;
        pipe_ch_d    = grant_any ? grant_ch : pipe_ch_q;
        pipe_err_d   = grant_any && grant_fault;

        // Only the channel whose read is in the memory stage captures; every
        // other channel's response registers hold.
        rsp_err_d = rsp_err_q;
        for (int c = 0; c < NCH; c++) begin
            rsp_data_d[c] = rsp_data_q[c];
            if ((state_q[c] == ST_INFLIGHT) && (pipe_ch_q == CH_W'(c))) begin
                rsp_data_d[c] = pipe_err_q ? '0 : mem_rdata;
                rsp_err_d[c]  = pipe_err_q;
            end
        end
    end

    // Outputs
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            rsp_valid[c]         = (state_q[c] == ST_HELD);
            rsp_data[c*DW +: DW] = rsp_data_q[c];
        end
    end

    assign req_ready = grant;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rom_port.sv
module tb_rom_port;

    localparam int WORDSIZE = 4;
    localparam int MEMSIZE  = 1024;
    localparam int NCH      = 2;
    localparam int ADDR_W   = 32;

    logic               clock;
    logic               reset_n;
    logic [NCH-1:0]     req_valid;
    logic [NCH-1:0]     req_ready;
    logic [NCH*32-1:0]  req_addr;
    logic [NCH-1:0]     rsp_valid;
    logic [NCH-1:0]     rsp_ready;
    logic [NCH*32-1:0]  rsp_data;
    logic [NCH-1:0]     rsp_err;

    int total = 0;
    int bad   = 0;

    rom_port #(
        .WORDSIZE (WORDSIZE),
        .MEMSIZE  (MEMSIZE),
        .NCH      (NCH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  rr;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_vld;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected per-cycle values for the backpressure sequence.
    logic [1:0] bp_rdy [10];
    logic [1:0] bp_vld [10];

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = '0;
        for (int i = 0; i < MEMSIZE / WORDSIZE; i++) begin
            dut.u_mem.mem[i] = 32'hA500_0000 + i;
        end

        // cycle table: contention from reset, single reads, address folding/faults
        vecs[0]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b01, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[1]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b10, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[2]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b00, 2'b01, 32'hA500_0000, 32'h0,         2'b00};
        vecs[3]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b01, 2'b10, 32'h0,         32'hA500_0001, 2'b00};
        vecs[4]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b10, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[5]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b00, 2'b01, 32'hA500_0000, 32'h0,         2'b00};
        vecs[6]  = '{2'b11, 32'h0,  32'h4,   2'b11, 2'b01, 2'b10, 32'h0,         32'hA500_0001, 2'b00};
        vecs[7]  = '{2'b00, 32'h0,  32'h4,   2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[8]  = '{2'b00, 32'h0,  32'h4,   2'b11, 2'b00, 2'b01, 32'hA500_0000, 32'h0,         2'b00};
        vecs[9]  = '{2'b01, 32'h10, 32'h0,   2'b11, 2'b01, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[10] = '{2'b00, 32'h10, 32'h0,   2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[11] = '{2'b00, 32'h10, 32'h0,   2'b11, 2'b00, 2'b01, 32'hA500_0004, 32'h0,         2'b00};
        vecs[12] = '{2'b10, 32'h0,  32'h404, 2'b11, 2'b10, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[13] = '{2'b00, 32'h0,  32'h404, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00};
`ifdef ROM_ERR_CHECK_EN
        vecs[14] = '{2'b00, 32'h0,  32'h404, 2'b11, 2'b00, 2'b10, 32'h0,         32'h0,         2'b10};
`else
        vecs[14] = '{2'b00, 32'h0,  32'h404, 2'b11, 2'b00, 2'b10, 32'h0,         32'hA500_0001, 2'b00};
`endif
        vecs[15] = '{2'b01, 32'h6,  32'h0,   2'b11, 2'b01, 2'b00, 32'h0,         32'h0,         2'b00};
        vecs[16] = '{2'b00, 32'h6,  32'h0,   2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         2'b00};
`ifdef ROM_ERR_CHECK_EN
        vecs[17] = '{2'b00, 32'h6,  32'h0,   2'b11, 2'b00, 2'b01, 32'h0,         32'h0,         2'b01};
`else
        vecs[17] = '{2'b00, 32'h6,  32'h0,   2'b11, 2'b00, 2'b01, 32'hA500_0001, 32'h0,         2'b00};
`endif

        bp_rdy = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        bp_vld = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_rsp_err",   64'(rsp_err),   64'h0);
        check("reset_rsp_data",  64'(rsp_data),  64'h0);
        check("reset_req_ready", 64'(req_ready), 64'h0);
        reset_n = 1'b1;

        for (int k = 0; k < 18; k++) begin
            check($sformatf("vec%0d_rsp_valid", k), 64'(rsp_valid), 64'(vecs[k].exp_vld));
            check($sformatf("vec%0d_rsp_err", k),   64'(rsp_err),   64'(vecs[k].exp_err));
            if (vecs[k].exp_vld[0])
                check($sformatf("vec%0d_data0", k), 64'(rsp_data[31:0]),  64'(vecs[k].exp_d0));
            if (vecs[k].exp_vld[1])
                check($sformatf("vec%0d_data1", k), 64'(rsp_data[63:32]), 64'(vecs[k].exp_d1));
            req_valid = vecs[k].rv;
            req_addr  = {vecs[k].a1, vecs[k].a0};
            rsp_ready = vecs[k].rr;
            #1;
            check($sformatf("vec%0d_req_ready", k), 64'(req_ready), 64'(vecs[k].exp_rdy));
            tick();
        end

        // backpressure: ch1 response held for several cycles while ch0 keeps going
        req_addr = {32'hC, 32'h8};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), 64'(rsp_valid), 64'(bp_vld[k]));
            if (bp_vld[k][1])
                check($sformatf("bp%0d_data1_hold", k), 64'(rsp_data[63:32]), 64'h0000_0000_A500_0003);
            if (bp_vld[k][0])
                check($sformatf("bp%0d_data0", k), 64'(rsp_data[31:0]), 64'h0000_0000_A500_0002);
            req_valid = 2'b11;
            rsp_ready = {(k >= 7) ? 1'b1 : 1'b0, 1'b1};
            #1;
            check($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'(bp_rdy[k]));
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) tick();
        check("drain_idle", 64'(rsp_valid), 64'h0);

        // reset while ch0's read is in flight
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'h10};
        #1;
        check("rst_pre_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data",  64'(rsp_data),  64'h0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_post%0d_rsp_valid", k), 64'(rsp_valid), 64'h0);
            tick();
        end
        req_valid = 2'b11;
        req_addr  = {32'h4, 32'h0};
        #1;
        check("rst_first_grant", 64'(req_ready), 64'h1);
        tick();
        check("rst_second_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        check("rst_resp0_valid", 64'(rsp_valid), 64'h1);
        check("rst_resp0_data",  64'(rsp_data[31:0]), 64'h0000_0000_A500_0000);
        tick();
        check("rst_resp1_valid", 64'(rsp_valid), 64'h2);
        check("rst_resp1_data",  64'(rsp_data[63:32]), 64'h0000_0000_A500_0001);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
